// File: rtl/clock_strobe_gen_if.sv
// Configuration port of clock_strobe_gen: a valid/ready request that
// carries a target channel and a new half-period divisor.
interface clock_strobe_gen_if #(
  parameter int channels_p = 2,
  parameter int width_p    = 8
);
  localparam int chan_w_lp = (channels_p > 1) ? $clog2(channels_p) : 1;

  logic                 cfg_v;
  logic [chan_w_lp-1:0] cfg_chan;
  logic [width_p-1:0]   cfg_div;
  logic                 cfg_ready;

  modport master (
    output cfg_v,
    output cfg_chan,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_v,
    input  cfg_chan,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clock_strobe_gen.sv
// Multi-channel clock-enable generator. Each channel produces a 50% duty
// divided clock (half-period = div cycles of clk_i) and a one-cycle tick on
// every rising edge of that clock. Divisors are reprogrammed through a
// valid/ready port and only take effect at a falling edge of the divided
// clock (or immediately when the channel is idle), so no shortened phase is
// ever produced. Dropping a channel's enable while its clock is high lets the
// high phase finish before the channel parks low.
module clock_strobe_gen #(
  parameter int channels_p    = 2,
  parameter int width_p       = 8,
  parameter int default_div_p = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [channels_p-1:0] en_i,
  clock_strobe_gen_if.slave     cfg,
  output logic [channels_p-1:0] clk_o,
  output logic [channels_p-1:0] tick_o
);

  localparam int chan_w_lp = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam logic [chan_w_lp:0]   chan_cnt_lp = channels_p[chan_w_lp:0];
  localparam logic [width_p-1:0]   zero_lp     = {width_p{1'b0}};
  localparam logic [width_p-1:0]   one_lp      = width_p'(1);
  localparam logic [width_p-1:0]   reset_div_lp = width_p'(default_div_p);

  // One-hot decode of the addressed channel (all zero when out of range).
  logic [channels_p-1:0] w_sel;
  // Per-channel pending flags gathered for the ready computation.
  logic [channels_p-1:0] w_pend_v;
  logic                  w_chan_ok;
  logic                  w_take;

  // Widen the channel index by one bit so the range check cannot truncate.
  assign w_chan_ok = ({1'b0, cfg.cfg_chan} < chan_cnt_lp);

  // Ready only drops while the addressed channel still holds a pending divisor;
  // an out-of-range channel has no pending slot, so it always reads ready.
  assign cfg.cfg_ready = ~|(w_sel & w_pend_v);

  // A handshake always completes, but only a valid channel with a non-zero
  // divisor actually loads the pending slot.
  assign w_take = cfg.cfg_v & cfg.cfg_ready & w_chan_ok & (cfg.cfg_div != zero_lp);

  for (genvar c = 0; c < channels_p; c++) begin : g_chan
    logic [width_p-1:0] r_cnt;
    logic [width_p-1:0] r_div;
    logic [width_p-1:0] r_pend_div;
    logic               r_clk;
    logic               r_tick;
    logic               r_pend_v;
    logic               r_stop;
    logic               w_run;
    logic               w_last;
    logic               w_rise;
    logic               w_fall;
    logic               w_load;
    logic               w_apply;

    assign w_sel[c]    = (cfg.cfg_chan == chan_w_lp'(c));
    assign w_pend_v[c] = r_pend_v;

    // A high phase always runs to completion, even with the enable gone.
    assign w_run  = en_i[c] | r_stop | r_clk;
    assign w_last = (r_cnt == (r_div - one_lp));
    assign w_rise = w_run & w_last & ~r_clk;
    assign w_fall = w_run & w_last & r_clk;
    assign w_load = w_take & w_sel[c];
    // Swap divisors only at a falling edge, or at once when the channel is parked.
    assign w_apply = r_pend_v & (w_fall | ~w_run);

    // Channel counter, divided clock, tick, stop flag and divisor update.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_cnt      <= zero_lp;
        r_div      <= reset_div_lp;
        r_pend_div <= zero_lp;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
        r_pend_v   <= 1'b0;
        r_stop     <= 1'b0;
      end else begin
        if (!w_run) begin
          r_cnt <= zero_lp;
        end else if (w_last) begin
          r_cnt <= zero_lp;
          r_clk <= ~r_clk;
        end else begin
          r_cnt <= r_cnt + one_lp;
        end

        r_tick <= w_rise;
        r_stop <= r_clk & ~en_i[c] & ~w_fall;

        if (w_apply) begin
          r_div    <= r_pend_div;
          r_pend_v <= 1'b0;
        end else if (w_load) begin
          r_pend_div <= cfg.cfg_div;
          r_pend_v   <= 1'b1;
        end else begin
          r_pend_v <= r_pend_v;
        end
      end
    end

    assign clk_o[c]  = r_clk;
    assign tick_o[c] = r_tick;
  end

endmodule

// File: tb/tb_clock_strobe_gen.sv
// Directed bench for clock_strobe_gen with three channels (two-bit channel
// index so an out-of-range index can be exercised). Inputs change on the
// falling edge; ready is sampled before the rising edge, registered outputs
// one time unit after it.
module tb_clock_strobe_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] clk_o;
  logic [2:0] tick_o;
  int         n_checks = 0;
  int         n_errors = 0;

  clock_strobe_gen_if #(.channels_p(3), .width_p(8)) cfg_if ();

  clock_strobe_gen #(
    .channels_p   (3),
    .width_p      (8),
    .default_div_p(1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (en),
    .cfg   (cfg_if.slave),
    .clk_o (clk_o),
    .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic       v;
    logic [1:0] chan;
    logic [7:0] div;
    logic       rdy;
    logic [2:0] clk;
    logic [2:0] tick;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input string name, input logic [2:0] e, input logic v,
                     input logic [1:0] ch, input logic [7:0] d, input logic r,
                     input logic [2:0] c, input logic [2:0] t);
    @(negedge clk);
    en              = e;
    cfg_if.cfg_v    = v;
    cfg_if.cfg_chan = ch;
    cfg_if.cfg_div  = d;
    #1;
    chk({name, " ready"}, {7'd0, cfg_if.cfg_ready}, {7'd0, r});
    @(posedge clk);
    #1;
    chk({name, " clk_o"}, {5'd0, clk_o}, {5'd0, c});
    chk({name, " tick_o"}, {5'd0, tick_o}, {5'd0, t});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n        = 1'b0;
    en           = 3'b000;
    cfg_if.cfg_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Period-2 clocks, then ch0 reprogrammed to 3 in the middle of a high phase.
    tbl[0]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011};
    tbl[1]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    tbl[2]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011};
    tbl[3]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    tbl[4]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011};
    tbl[5]  = '{3'b011, 1'b1, 2'd0, 8'd3, 1'b1, 3'b000, 3'b000};
    tbl[6]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b011};
    tbl[7]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000};
    tbl[8]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b010, 3'b010};
    tbl[9]  = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    tbl[10] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011};
    tbl[11] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b001, 3'b000};
    tbl[12] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b010};
    tbl[13] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    tbl[14] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b010, 3'b010};
    tbl[15] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    tbl[16] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011};
    tbl[17] = '{3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b001, 3'b000};

    // Reset holds everything low even with the enables asserted.
    rst_n           = 1'b0;
    en              = 3'b011;
    cfg_if.cfg_v    = 1'b0;
    cfg_if.cfg_chan = 2'd0;
    cfg_if.cfg_div  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset clk_o", {5'd0, clk_o}, 8'd0);
    chk("reset tick_o", {5'd0, tick_o}, 8'd0);
    chk("reset ready", {7'd0, cfg_if.cfg_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 3'b000;

    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].v, tbl[i].chan, tbl[i].div,
          tbl[i].rdy, tbl[i].clk, tbl[i].tick);
    end

    // Back-to-back requests to ch1 while its div=5 clock is high.
    reset_dut();
    cyc("t3 load5", 3'b000, 1'b1, 2'd1, 8'd5, 1'b1, 3'b000, 3'b000);
    cyc("t3 apply5", 3'b000, 1'b0, 2'd1, 8'd0, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) cyc("t3 low", 3'b010, 1'b0, 2'd1, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t3 rise", 3'b010, 1'b0, 2'd1, 8'd0, 1'b1, 3'b010, 3'b010);
    cyc("t3 reqA", 3'b010, 1'b1, 2'd1, 8'd2, 1'b1, 3'b010, 3'b000);
    for (int i = 0; i < 3; i++) cyc("t3 blocked", 3'b010, 1'b1, 2'd1, 8'd3, 1'b0, 3'b010, 3'b000);
    cyc("t3 fallA", 3'b010, 1'b1, 2'd1, 8'd3, 1'b0, 3'b000, 3'b000);
    cyc("t3 reqB", 3'b010, 1'b1, 2'd1, 8'd3, 1'b1, 3'b000, 3'b000);
    cyc("t3 riseA", 3'b010, 1'b0, 2'd1, 8'd0, 1'b0, 3'b010, 3'b010);
    cyc("t3 highA", 3'b010, 1'b0, 2'd1, 8'd0, 1'b0, 3'b010, 3'b000);
    cyc("t3 fallB", 3'b010, 1'b0, 2'd1, 8'd0, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 2; i++) cyc("t3 lowB", 3'b010, 1'b0, 2'd1, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t3 riseB", 3'b010, 1'b0, 2'd1, 8'd0, 1'b1, 3'b010, 3'b010);
    for (int i = 0; i < 2; i++) cyc("t3 highB", 3'b010, 1'b0, 2'd1, 8'd0, 1'b1, 3'b010, 3'b000);
    cyc("t3 endB", 3'b010, 1'b0, 2'd1, 8'd0, 1'b1, 3'b000, 3'b000);

    // Enable dropped two cycles into a 4-cycle high phase, then re-enabled.
    reset_dut();
    cyc("t4 load4", 3'b000, 1'b1, 2'd0, 8'd4, 1'b1, 3'b000, 3'b000);
    cyc("t4 apply4", 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cyc("t4 low", 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t4 rise", 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 3'b001, 3'b001);
    cyc("t4 high", 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 3'b001, 3'b000);
    for (int i = 0; i < 2; i++) cyc("t4 hold", 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 3'b001, 3'b000);
    cyc("t4 fall", 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);
    for (int i = 0; i < 6; i++) cyc("t4 parked", 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cyc("t4 restart", 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t4 rerise", 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 3'b001, 3'b001);

    // Zero divisor and out-of-range channel are accepted but ignored.
    reset_dut();
    cyc("t5 div0", 3'b011, 1'b1, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011);
    cyc("t5 chan3", 3'b011, 1'b1, 2'd3, 8'd9, 1'b1, 3'b000, 3'b000);
    cyc("t5 ch0", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011);
    cyc("t5 ch1", 3'b011, 1'b0, 2'd1, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t5 ch2", 3'b011, 1'b0, 2'd2, 8'd0, 1'b1, 3'b011, 3'b011);
    cyc("t5 ch3", 3'b011, 1'b0, 2'd3, 8'd0, 1'b1, 3'b000, 3'b000);

    // Mid-run reset with div=7 on both channels and a pend outstanding.
    reset_dut();
    cyc("t6 load0", 3'b000, 1'b1, 2'd0, 8'd7, 1'b1, 3'b000, 3'b000);
    cyc("t6 load1", 3'b000, 1'b1, 2'd1, 8'd7, 1'b1, 3'b000, 3'b000);
    cyc("t6 apply1", 3'b000, 1'b0, 2'd1, 8'd0, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 6; i++) cyc("t6 low", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t6 rise", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011);
    cyc("t6 req", 3'b011, 1'b1, 2'd0, 8'd2, 1'b1, 3'b011, 3'b000);
    cyc("t6 pend", 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b000);
    rst_n = 1'b0;
    cyc("t6 rst", 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000);
    rst_n = 1'b1;
    cyc("t6 post1", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011);
    cyc("t6 post2", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);
    cyc("t6 post3", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b011);
    cyc("t6 post4", 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
